// File: rtl/bus_periph_pkg.sv
// Shared definitions for bus-attached peripherals: timer register map, bus idle value, IRQ index.
// BUS_TIMER_CAPTURE_EN widens the timer window to include CAPTURE_HI.
package bus_periph_pkg;

  localparam logic [7:0] TIMER_OFF_TIME_LO    = 8'd0;
  localparam logic [7:0] TIMER_OFF_RATE       = 8'd1;
  localparam logic [7:0] TIMER_OFF_CLEAR      = 8'd2;
  localparam logic [7:0] TIMER_OFF_CTRL       = 8'd3;
  localparam logic [7:0] TIMER_OFF_CAPTURE_HI = 8'd4;

  localparam logic [7:0] BUS_Z = 8'hZZ;

  localparam int unsigned TIMER_IRQ_IDX = 1;

`ifdef BUS_TIMER_CAPTURE_EN
  localparam logic [7:0] TIMER_WINDOW = 8'd5;
`else
  localparam logic [7:0] TIMER_WINDOW = 8'd4;
`endif

  // Offset is taken modulo 256, so a window near the top of the map wraps cleanly.
  function automatic logic timer_in_window(logic [7:0] offset);
    return offset < TIMER_WINDOW;
  endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Shared 8-bit processor bus with interrupt raise/ack pair.
// Each side owns one tristate driver onto BUS_DATA; both resolve on the wire here.
interface bus_timer_if;
  import bus_periph_pkg::*;

  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;
  wire  [7:0] BUS_DATA;

  logic [7:0] wdata;
  logic       wdata_oe;
  logic [7:0] rdata;
  logic       rdata_oe;

  assign BUS_DATA = wdata_oe ? wdata : BUS_Z;
  assign BUS_DATA = rdata_oe ? rdata : BUS_Z;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    output wdata,
    output wdata_oe,
    input  BUS_INTERRUPT_RAISE,
    input  BUS_DATA
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    input  BUS_DATA,
    output BUS_INTERRUPT_RAISE,
    output rdata,
    output rdata_oe
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides CLK down to a one-cycle tick every TERM+1 enabled cycles.
module tick_prescaler #(
  parameter int unsigned TERM = 9
) (
  input  logic CLK,
  input  logic RESET,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TERM == 0) ? 1 : $clog2(TERM + 1);
  localparam logic [CntW-1:0] TermC = CntW'(TERM);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i & (cnt_q == TermC);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped millisecond timer: free-running tick count, programmable interrupt interval.
// Define BUS_TIMER_CAPTURE_EN to add CAPTURE_HI at +4 for coherent 16-bit reads.
module bus_timer
  import bus_periph_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'hF0,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter logic [7:0]  RATE_RESET  = 8'd100
) (
  input logic        CLK,
  input logic        RESET,
  bus_timer_if.slave bus
);

  localparam int unsigned TickDiv = (TICK_HZ == 0) ? 0 : CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned TERM    = (TickDiv == 0) ? 0 : TickDiv - 1;

  if (TickDiv == 0 || TickDiv * TICK_HZ != CLK_FREQ_HZ) begin : gen_bad_freq
    $error("bus_timer: CLK_FREQ_HZ must be an exact non-zero multiple of TICK_HZ");
  end

  logic [15:0] tick_count_q, tick_count_d;
  logic [7:0]  interval_q, interval_d;
  logic [7:0]  rate_q, rate_d;
  logic        enable_q, enable_d;
  logic        raise_q, raise_d;
  logic        rd_strobe_q, rd_strobe_d;
  logic [7:0]  rd_data_q, rd_data_d;
`ifdef BUS_TIMER_CAPTURE_EN
  logic [7:0]  capture_q, capture_d;
`endif

  logic [7:0] offset;
  logic       hit, wr_en, rd_en, clear_wr;
  logic       tick, tick_ok, irq_event;
  logic [7:0] interval_inc;
  logic [7:0] rd_mux;

  assign offset   = bus.BUS_ADDR - BASE_ADDR;
  assign hit      = timer_in_window(offset);
  assign wr_en    = hit & bus.BUS_WE;
  assign rd_en    = hit & ~bus.BUS_WE;
  assign clear_wr = wr_en & (offset == TIMER_OFF_CLEAR);

  tick_prescaler #(
    .TERM (TERM)
  ) u_prescaler (
    .CLK      (CLK),
    .RESET    (RESET),
    .enable_i (enable_q),
    .clear_i  (clear_wr),
    .tick_o   (tick)
  );

  // A tick landing on a CLEAR write is swallowed along with the counters.
  assign tick_ok      = tick & ~clear_wr;
  assign interval_inc = interval_q + 8'd1;
  assign irq_event    = tick_ok & (rate_q != 8'd0) & (interval_inc == rate_q);

  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      TIMER_OFF_TIME_LO:    rd_mux = tick_count_q[7:0];
      TIMER_OFF_RATE:       rd_mux = rate_q;
      TIMER_OFF_CTRL:       rd_mux = {7'd0, enable_q};
`ifdef BUS_TIMER_CAPTURE_EN
      TIMER_OFF_CAPTURE_HI: rd_mux = capture_q;
`endif
      default:              rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    tick_count_d = tick_count_q;
    interval_d   = interval_q;
    rate_d       = rate_q;
    enable_d     = enable_q;
    raise_d      = raise_q;
    rd_strobe_d  = rd_en;
    rd_data_d    = rd_data_q;

    if (clear_wr) begin
      tick_count_d = '0;
      interval_d   = '0;
    end else if (tick_ok) begin
      tick_count_d = tick_count_q + 16'd1;
      interval_d   = ((rate_q == 8'd0) || irq_event) ? 8'd0 : interval_inc;
    end

    if (wr_en && (offset == TIMER_OFF_RATE)) begin
      rate_d = bus.BUS_DATA;
    end
    if (wr_en && (offset == TIMER_OFF_CTRL)) begin
      enable_d = bus.BUS_DATA[0];
    end

    // A fresh event outranks a simultaneous acknowledge.
    if (irq_event) begin
      raise_d = 1'b1;
    end else if (bus.BUS_INTERRUPT_ACK) begin
      raise_d = 1'b0;
    end

    if (rd_en) begin
      rd_data_d = rd_mux;
    end
  end

`ifdef BUS_TIMER_CAPTURE_EN
  always_comb begin
    capture_d = capture_q;
    if (rd_en && (offset == TIMER_OFF_TIME_LO)) begin
      capture_d = tick_count_q[15:8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      capture_q <= 8'h00;
    end else begin
      capture_q <= capture_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_count_q <= '0;
      interval_q   <= '0;
      rate_q       <= RATE_RESET;
      enable_q     <= 1'b1;
      raise_q      <= 1'b0;
      rd_strobe_q  <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      tick_count_q <= tick_count_d;
      interval_q   <= interval_d;
      rate_q       <= rate_d;
      enable_q     <= enable_d;
      raise_q      <= raise_d;
      rd_strobe_q  <= rd_strobe_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.BUS_INTERRUPT_RAISE = raise_q;
  assign bus.rdata               = rd_data_q;
  assign bus.rdata_oe            = rd_strobe_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer with a 10-CLK tick; edge numbers below count CLK rising edges.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  bus_timer_if bus ();

  bus_timer #(
    .BASE_ADDR   (8'hF0),
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100),
    .RATE_RESET  (8'd100)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after rising edge n.
  task automatic goto(input int unsigned n);
    chk("sched", {7'd0, (cyc <= n)}, 8'd1);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Read registered at edge 'at'; data is sampled in the following cycle.
  task automatic rd_chk(input string tag, input logic [7:0] a, input int unsigned at,
                        input logic [7:0] exp);
    goto(at - 1);
    bus.BUS_ADDR = a;
    @(posedge clk);
    #1;
    chk({tag, "_drv"}, {7'd0, bus.rdata_oe}, 8'd1);
    chk(tag, bus.BUS_DATA, exp);
    bus.BUS_ADDR = 8'h00;
    @(posedge clk);
    #1;
    chk({tag, "_rel"}, {7'd0, bus.rdata_oe}, 8'd0);
  endtask

  task automatic rd_z(input string tag, input logic [7:0] a, input int unsigned at);
    goto(at - 1);
    bus.BUS_ADDR = a;
    @(posedge clk);
    #1;
    chk(tag, {7'd0, bus.rdata_oe}, 8'd0);
    bus.BUS_ADDR = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int unsigned at);
    goto(at - 1);
    bus.BUS_ADDR = a;
    bus.wdata    = d;
    bus.wdata_oe = 1'b1;
    bus.BUS_WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.BUS_WE   = 1'b0;
    bus.wdata_oe = 1'b0;
    bus.BUS_ADDR = 8'h00;
  endtask

  task automatic ack_at(input int unsigned n);
    goto(n - 1);
    bus.BUS_INTERRUPT_ACK = 1'b1;
    @(posedge clk);
    #1;
    bus.BUS_INTERRUPT_ACK = 1'b0;
  endtask

  function automatic logic [7:0] raise8();
    return {7'd0, bus.BUS_INTERRUPT_RAISE};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.BUS_ADDR          = 8'h00;
    bus.BUS_WE            = 1'b0;
    bus.BUS_INTERRUPT_ACK = 1'b0;
    bus.wdata             = 8'h00;
    bus.wdata_oe          = 1'b0;

    // Reset: held for edges 1..3; prescaler runs from edge 4, so ticks land on edges 3+10k.
    goto(3);
    rst = 1'b0;
    chk("rst_raise", raise8(), 8'd0);
    chk("rst_drv", {7'd0, bus.rdata_oe}, 8'd0);
    rd_chk("rst_rate", 8'hF1, 4, 8'd100);
    rd_chk("rst_ctrl", 8'hF3, 6, 8'h01);

    // Counting and 8-bit wrap of TIME_LO (256th tick at edge 2563).
    rd_chk("lo_pre_tick", 8'hF0, 13, 8'h00);
    rd_chk("lo_tick1", 8'hF0, 15, 8'h01);
    rd_chk("lo_255", 8'hF0, 2563, 8'hFF);
    rd_chk("lo_wrap", 8'hF0, 2565, 8'h00);
`ifdef BUS_TIMER_CAPTURE_EN
    rd_chk("cap_hi", 8'hF4, 2567, 8'h01);
`endif

    // Interrupt interval of 3 ticks; clear at 2571 moves ticks to edges 2571+10k.
    wr(8'hF1, 8'd3, 2570);
    wr(8'hF2, 8'h00, 2571);
    chk("raise_old", raise8(), 8'd1);
    ack_at(2572);
    chk("ack_clear", raise8(), 8'd0);
    goto(2600);
    chk("pre_event", raise8(), 8'd0);
    goto(2601);
    chk("event1", raise8(), 8'd1);
    goto(2651);
    chk("hold50", raise8(), 8'd1);
    ack_at(2652);
    chk("ack2", raise8(), 8'd0);
    goto(2660);
    chk("pre_event3", raise8(), 8'd0);
    goto(2661);
    chk("event3", raise8(), 8'd1);

    // ACK coincident with the event at 2691, then ACK while idle.
    ack_at(2691);
    chk("collide", raise8(), 8'd1);
    ack_at(2692);
    chk("ack3", raise8(), 8'd0);
    ack_at(2700);
    chk("ack_idle", raise8(), 8'd0);
    goto(2721);
    chk("event5", raise8(), 8'd1);

    // Disable: 15 ticks since the clear, then frozen.
    wr(8'hF3, 8'h00, 2730);
    rd_chk("dis_lo", 8'hF0, 2732, 8'h0F);
    rd_chk("dis_hold", 8'hF0, 2835, 8'h0F);
    rd_chk("dis_ctrl", 8'hF3, 2837, 8'h00);

    // Re-enable with prescaler parked at terminal, so CLEAR at 2841 hits a tick cycle.
    wr(8'hF3, 8'h01, 2840);
    wr(8'hF2, 8'h00, 2841);
    rd_chk("clr_lo", 8'hF0, 2843, 8'h00);
    rd_chk("clr_pre", 8'hF0, 2851, 8'h00);
    rd_chk("clr_tick", 8'hF0, 2853, 8'h01);

    // Bus hygiene.
    rd_z("unmap_f5", 8'hF5, 2860);
    rd_z("unmap_10", 8'h10, 2862);
`ifdef BUS_TIMER_CAPTURE_EN
    rd_chk("cap_hi2", 8'hF4, 2864, 8'h00);
`else
    rd_z("unmap_f4", 8'hF4, 2864);
`endif
    rd_chk("clear_rd", 8'hF2, 2866, 8'h00);

    // Reset asserted while a read is driving.
    goto(2869);
    bus.BUS_ADDR = 8'hF1;
    @(posedge clk);
    #1;
    chk("mid_drv", {7'd0, bus.rdata_oe}, 8'd1);
    chk("mid_data", bus.BUS_DATA, 8'd3);
    chk("mid_raise", raise8(), 8'd1);
    rst          = 1'b1;
    bus.BUS_ADDR = 8'h00;
    @(posedge clk);
    #1;
    chk("mid_rst_drv", {7'd0, bus.rdata_oe}, 8'd0);
    chk("mid_rst_raise", raise8(), 8'd0);
    rst = 1'b0;
    rd_chk("post_rate", 8'hF1, 2873, 8'd100);
    rd_chk("post_lo", 8'hF0, 2875, 8'h00);
    rd_chk("post_ctrl", 8'hF3, 2877, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
